// File: rtl/lc3_pkg.sv
// LC3 sequencer shared definitions: opcodes, states,
// address-select codes, opcode classes and control bundle.
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RES  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  localparam logic [7:0] TRAP_HALT_VEC = 8'h25;

  localparam logic [1:0] SEL_PC  = 2'b00;
  localparam logic [1:0] SEL_EA  = 2'b01;
  localparam logic [1:0] SEL_IND = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_IND,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef struct packed {
    logic is_ld;
    logic is_st;
    logic is_ind;
    logic wr_reg;
    logic wr_cc;
    logic illegal;
  } op_class_t;

  typedef struct packed {
    logic       fetch_start;
    logic       ir_ld;
    logic       ind_ld;
    logic       mem_rd_en;
    logic       wea;
    logic [1:0] addr_sel;
    logic       reg_we;
    logic       cc_we;
    logic       busy;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/lc3_op_decode.sv
// LC3 opcode classifier: maps ir[15:12] onto the
// sequencing class used by the instruction-cycle FSM.
module lc3_op_decode
  import lc3_pkg::*;
(
  input  logic [3:0] op_i,
  output op_class_t  cls_o
);

  // Pure opcode lookup; BR and JMP fall to the all-zero class.
  always_comb begin
    cls_o = '0;
    unique case (op_i)
      OP_ADD, OP_AND, OP_NOT: begin
        cls_o.wr_reg = 1'b1;
        cls_o.wr_cc  = 1'b1;
      end
      OP_LD, OP_LDR: begin
        cls_o.is_ld  = 1'b1;
        cls_o.wr_reg = 1'b1;
        cls_o.wr_cc  = 1'b1;
      end
      OP_LDI: begin
        cls_o.is_ld  = 1'b1;
        cls_o.is_ind = 1'b1;
        cls_o.wr_reg = 1'b1;
        cls_o.wr_cc  = 1'b1;
      end
      OP_ST, OP_STR: begin
        cls_o.is_st = 1'b1;
      end
      OP_STI: begin
        cls_o.is_st  = 1'b1;
        cls_o.is_ind = 1'b1;
      end
      OP_LEA, OP_JSR, OP_TRAP: begin
        cls_o.wr_reg = 1'b1;
      end
      OP_RTI, OP_RES: begin
        cls_o.illegal = 1'b1;
      end
      default: begin
        cls_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/lc3_seq_ctrl.sv
// LC3 instruction-cycle sequencer with registered controls.
// Optional: define TRAP_HALT_EN to make TRAP x25 halt the core.
module lc3_seq_ctrl
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step_en,
  input  logic [15:0]      ir_in,
  output logic             fetch_start,
  output logic             ir_ld,
  output logic             ind_ld,
  output logic             mem_rd_en,
  output logic             wea_out,
  output logic [1:0]       addr_sel,
  output logic             reg_we,
  output logic             cc_we,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  ctrl_t            ctrl_q, ctrl_d;
  op_class_t        cls;
  logic             last;
  logic             trap_halt;
  logic             unused_ir;

  assign unused_ir = ^ir_in[11:0];

  lc3_op_decode u_dec (
    .op_i  (op_q),
    .cls_o (cls)
  );

`ifdef TRAP_HALT_EN
  logic [7:0] vec_q;

  // Trap vector captured alongside the opcode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_q <= '0;
    end else if (state_q == S_FETCH && last) begin
      vec_q <= ir_in[7:0];
    end
  end

  assign trap_halt = (op_q == OP_TRAP) &&
                     (vec_q == TRAP_HALT_VEC);
`else
  assign trap_halt = 1'b0;
`endif

  assign last = (cnt_q == LAST);

  // Next state, cycle counter and the controls for next cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    icnt_d  = icnt_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_HALT: begin
        if (run) begin
          state_d = S_FETCH;
          err_d   = 1'b0;
        end
      end
      S_FETCH: begin
        if (last) begin
          state_d = S_DECODE;
          op_d    = ir_in[15:12];
        end
      end
      S_DECODE: begin
        if (cls.illegal) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls.is_ind) state_d = S_IND;
        else if (cls.is_ld || cls.is_st) state_d = S_MEM;
        else state_d = S_WB;
      end
      S_IND: begin
        if (last) state_d = S_MEM;
      end
      S_MEM: begin
        if (cls.is_st || last) state_d = S_WB;
      end
      S_WB: begin
        if (trap_halt) begin
          state_d = S_HALT;
        end else begin
          icnt_d  = icnt_q + CNT_W'(1);
          state_d = step_en ? S_IDLE : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cnt_d = (state_d == state_q) ? cnt_q + CW'(1) : '0;

    ctrl_d      = '0;
    ctrl_d.busy = (state_d != S_IDLE) && (state_d != S_HALT);
    case (state_d)
      S_FETCH: begin
        ctrl_d.mem_rd_en = 1'b1;
        ctrl_d.addr_sel  = SEL_PC;
        ctrl_d.ir_ld     = (cnt_d == LAST);
      end
      S_IND: begin
        ctrl_d.mem_rd_en = 1'b1;
        ctrl_d.addr_sel  = SEL_EA;
        ctrl_d.ind_ld    = (cnt_d == LAST);
      end
      S_MEM: begin
        ctrl_d.addr_sel  = cls.is_ind ? SEL_IND : SEL_EA;
        ctrl_d.wea       = cls.is_st;
        ctrl_d.mem_rd_en = !cls.is_st;
      end
      S_WB: begin
        ctrl_d.reg_we      = cls.wr_reg;
        ctrl_d.cc_we       = cls.wr_cc;
        ctrl_d.fetch_start = !trap_halt;
      end
      S_HALT: begin
        ctrl_d.halted = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer state and registered control outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_BR;
      err_q   <= 1'b0;
      icnt_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      err_q   <= err_d;
      icnt_q  <= icnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign fetch_start = ctrl_q.fetch_start;
  assign ir_ld       = ctrl_q.ir_ld;
  assign ind_ld      = ctrl_q.ind_ld;
  assign mem_rd_en   = ctrl_q.mem_rd_en;
  assign wea_out     = ctrl_q.wea;
  assign addr_sel    = ctrl_q.addr_sel;
  assign reg_we      = ctrl_q.reg_we;
  assign cc_we       = ctrl_q.cc_we;
  assign busy        = ctrl_q.busy;
  assign halted      = ctrl_q.halted;
  assign err         = err_q;
  assign instr_cnt   = icnt_q;

endmodule

// File: tb/tb_lc3_seq_ctrl.sv
// Directed bench for lc3_seq_ctrl at MEM_LAT=2.
// Expectations follow TRAP_HALT_EN when it is defined.
module tb_lc3_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step_en;
  logic [15:0] ir_in;
  logic        fetch_start;
  logic        ir_ld;
  logic        ind_ld;
  logic        mem_rd_en;
  logic        wea_out;
  logic [1:0]  addr_sel;
  logic        reg_we;
  logic        cc_we;
  logic        busy;
  logic        halted;
  logic        err;
  logic [15:0] instr_cnt;

  int checks;
  int errors;
  int exp_cnt;

  // {fs, ir_ld, ind_ld, rd, wea, sel[1:0], reg_we, cc_we,
  //  busy, halted, err}
  logic [11:0] obs;

  localparam logic [11:0] IDL    = 12'h000;
  localparam logic [11:0] FT0    = 12'h104;
  localparam logic [11:0] FT1    = 12'h504;
  localparam logic [11:0] BSY    = 12'h004;
  localparam logic [11:0] RD_EA  = 12'h124;
  localparam logic [11:0] IND1   = 12'h324;
  localparam logic [11:0] RD_IND = 12'h144;
  localparam logic [11:0] WR_EA  = 12'h0A4;
  localparam logic [11:0] WR_IND = 12'h0C4;
  localparam logic [11:0] WB_ALU = 12'h81C;
  localparam logic [11:0] WB_ST  = 12'h804;
  localparam logic [11:0] WB_JSR = 12'h814;
  localparam logic [11:0] WB_TH  = 12'h014;
  localparam logic [11:0] HLT    = 12'h002;
  localparam logic [11:0] HLT_E  = 12'h003;

  assign obs = {fetch_start, ir_ld, ind_ld, mem_rd_en,
                wea_out, addr_sel, reg_we, cc_we,
                busy, halted, err};

  lc3_seq_ctrl #(
    .MEM_LAT (2),
    .CNT_W   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .step_en     (step_en),
    .ir_in       (ir_in),
    .fetch_start (fetch_start),
    .ir_ld       (ir_ld),
    .ind_ld      (ind_ld),
    .mem_rd_en   (mem_rd_en),
    .wea_out     (wea_out),
    .addr_sel    (addr_sel),
    .reg_we      (reg_we),
    .cc_we       (cc_we),
    .busy        (busy),
    .halted      (halted),
    .err         (err),
    .instr_cnt   (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic step(input string tag,
                      input logic [11:0] e);
    @(posedge clk);
    #1;
    chk(tag, 32'(obs), 32'(e));
  endtask

  task automatic chk_cnt(input string tag);
    chk(tag, 32'(instr_cnt), 32'(exp_cnt));
  endtask

  // Launch from IDLE/HALT and walk FETCH plus DECODE.
  task automatic start(input string tag,
                       input logic [15:0] ir);
    ir_in = ir;
    run   = 1'b1;
    step({tag, ".f0"}, FT0);
    run   = 1'b0;
    step({tag, ".f1"}, FT1);
    step({tag, ".dec"}, BSY);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;
    rst_n   = 1'b0;
    run     = 1'b0;
    step_en = 1'b1;
    ir_in   = 16'h0000;

    // T1 reset
    repeat (5) @(posedge clk);
    #1;
    chk("rst.out", 32'(obs), 32'(IDL));
    chk_cnt("rst.cnt");
    rst_n = 1'b1;
    step("t1.idle", IDL);
    step("t1.idle2", IDL);

    // T2 ADD
    start("add", 16'h1261);
    step("add.ex", BSY);
    step("add.wb", WB_ALU);
    exp_cnt++;
    step("add.idle", IDL);
    chk_cnt("add.cnt");

    // T3 LDI
    start("ldi", 16'hA402);
    step("ldi.ex", BSY);
    step("ldi.ind0", RD_EA);
    step("ldi.ind1", IND1);
    step("ldi.mem0", RD_IND);
    step("ldi.mem1", RD_IND);
    step("ldi.wb", WB_ALU);
    exp_cnt++;
    step("ldi.idle", IDL);
    chk_cnt("ldi.cnt");

    // T4 ST
    start("st", 16'h3001);
    step("st.ex", BSY);
    step("st.wr", WR_EA);
    step("st.wb", WB_ST);
    exp_cnt++;
    step("st.idle", IDL);
    chk_cnt("st.cnt");

    // STI writes through the indirect pointer
    start("sti", 16'hB402);
    step("sti.ex", BSY);
    step("sti.ind0", RD_EA);
    step("sti.ind1", IND1);
    step("sti.wr", WR_IND);
    step("sti.wb", WB_ST);
    exp_cnt++;
    step("sti.idle", IDL);

    // JMP: no register or cc write
    start("jmp", 16'hC1C0);
    step("jmp.ex", BSY);
    step("jmp.wb", WB_ST);
    exp_cnt++;
    step("jmp.idle", IDL);
    chk_cnt("jmp.cnt");

    // Back-to-back run with step_en=0
    step_en = 1'b0;
    start("b2b", 16'h5020);
    step("b2b.ex", BSY);
    step("b2b.wb", WB_ALU);
    exp_cnt++;
    step("b2b.f0", FT0);
    step_en = 1'b1;
    step("b2b.f1", FT1);
    step("b2b.dec", BSY);
    step("b2b.ex2", BSY);
    step("b2b.wb2", WB_ALU);
    exp_cnt++;
    step("b2b.idle", IDL);
    chk_cnt("b2b.cnt");

    // T5 RTI halts with err, run resumes
    start("rti", 16'h8000);
    step("rti.halt", HLT_E);
    step("rti.hold", HLT_E);
    chk_cnt("rti.cnt");
    start("resume", 16'h1261);
    step("resume.ex", BSY);
    step("resume.wb", WB_ALU);
    exp_cnt++;
    step("resume.idle", IDL);

    // Reserved opcode 1101 also halts with err
    start("res", 16'hD000);
    step("res.halt", HLT_E);
    start("res.go", 16'h1261);
    step("res.go.ex", BSY);
    step("res.go.wb", WB_ALU);
    exp_cnt++;
    step("res.go.idle", IDL);
    chk_cnt("res.cnt");

    // TRAP x20 always behaves like JSR
    start("trap20", 16'hF020);
    step("trap20.ex", BSY);
    step("trap20.wb", WB_JSR);
    exp_cnt++;
    step("trap20.idle", IDL);

    // T6 TRAP x25
    start("trap25", 16'hF025);
    step("trap25.ex", BSY);
`ifdef TRAP_HALT_EN
    step("trap25.wb", WB_TH);
    step("trap25.halt", HLT);
    chk_cnt("trap25.cnt");
    start("trap25.go", 16'h1261);
    step("trap25.go.ex", BSY);
    step("trap25.go.wb", WB_ALU);
    exp_cnt++;
    step("trap25.go.idle", IDL);
`else
    step("trap25.wb", WB_JSR);
    exp_cnt++;
    step("trap25.idle", IDL);
`endif
    chk_cnt("trap25.cnt2");

    // Mid-op reset during an LD read
    start("ld", 16'h2002);
    step("ld.ex", BSY);
    step("ld.mem0", RD_EA);
    rst_n = 1'b0;
    step("ld.rst", IDL);
    exp_cnt = 0;
    chk_cnt("ld.rst.cnt");
    rst_n = 1'b1;
    step("ld.after", IDL);
    chk_cnt("ld.after.cnt");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
